mcpu_ctrl_alu: RTL and testbench



---
 rtl/mcpu_ctrl_alu.sv | 244 ++++++++++++++++++++++++
 tb/tb_mcpu_ctrl_alu.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_ctrl_alu.sv
// Control and execute core of the multicycle MIPS-subset CPU: tick divider,
// instruction-sequencing FSM and ALU with its operand muxes.
module mcpu_ctrl_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] div,
  input  logic [31:0] ir_data,
  input  logic [31:0] a_data,
  input  logic [31:0] b_data,
  input  logic [31:0] pc,
  output logic        tick,
  output logic        write_pc,
  output logic        iord,
  output logic        write_mem,
  output logic        write_dr,
  output logic        write_ir,
  output logic        write_c,
  output logic        write_a,
  output logic        write_b,
  output logic        write_reg,
  output logic        memtoreg,
  output logic        regdst,
  output logic [1:0]  pcsource,
  output logic [1:0]  alu_ctrl,
  output logic        alu_srcA,
  output logic [1:0]  alu_srcB,
  output logic [31:0] alu_out,
  output logic        zero,
  output logic [3:0]  state_out,
  output logic [3:0]  insn_type,
  output logic [3:0]  insn_code,
  output logic [2:0]  insn_stage
);

  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
    S_LW_WB = 4'd4, S_SW = 4'd5, S_R_EX = 4'd6, S_R_WB = 4'd7,
    S_BEQ = 4'd8, S_J = 4'd9, S_I_EX = 4'd10, S_I_WB = 4'd11
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_cnt, r_lim, w_limNow;
  logic [5:0]  w_op, w_funct;
  logic [31:0] w_imm, w_immSh, w_srcA, w_srcB;
  logic        w_wPc, w_wMem, w_wDr, w_wIr, w_wC, w_wA, w_wB, w_wReg;
  logic        w_beqPc, w_gate;
  logic        w_unused;

  // The new period length is sampled only at counter zero, so a div change
  // never shortens or stretches the period already in progress.
  assign w_limNow = (div == 32'd0) ? 32'd0 : div - 32'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 32'd0;
      r_lim <= 32'd0;
    end else if (r_cnt == 32'd0) begin
      r_lim <= w_limNow;
      r_cnt <= (w_limNow == 32'd0) ? 32'd0 : 32'd1;
    end else if (r_cnt >= r_lim) begin
      r_cnt <= 32'd0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign tick = (r_cnt == 32'd0);

  assign w_op     = ir_data[31:26];
  assign w_funct  = ir_data[5:0];
  assign w_unused = ^ir_data[25:16];

  always_comb begin
    insn_type = 4'd0;
    insn_code = 4'd0;
    case (w_op)
      6'h00: begin
        case (w_funct)
          6'h20: begin insn_type = 4'd1; insn_code = 4'd0; end
          6'h22: begin insn_type = 4'd1; insn_code = 4'd1; end
          6'h24: begin insn_type = 4'd1; insn_code = 4'd2; end
          6'h25: begin insn_type = 4'd1; insn_code = 4'd3; end
          default: ;
        endcase
      end
      6'h08: begin insn_type = 4'd2; insn_code = 4'd0; end
      6'h0C: begin insn_type = 4'd2; insn_code = 4'd2; end
      6'h0D: begin insn_type = 4'd2; insn_code = 4'd3; end
      6'h23: insn_type = 4'd3;
      6'h2B: insn_type = 4'd4;
      6'h04: insn_type = 4'd5;
      6'h02: insn_type = 4'd6;
      default: ;
    endcase
  end

  // Logical immediates are zero-extended; everything else sign-extends.
  assign w_imm   = (w_op == 6'h0C || w_op == 6'h0D) ? {16'h0000, ir_data[15:0]}
                                                    : {{16{ir_data[15]}}, ir_data[15:0]};
  assign w_immSh = {{14{ir_data[15]}}, ir_data[15:0], 2'b00};

  assign w_srcA = alu_srcA ? a_data : pc;

  always_comb begin
    case (alu_srcB)
      2'b00:   w_srcB = b_data;
      2'b01:   w_srcB = 32'd4;
      2'b10:   w_srcB = w_imm;
      default: w_srcB = w_immSh;
    endcase
  end

  always_comb begin
    case (alu_ctrl)
      2'b00:   alu_out = w_srcA + w_srcB;
      2'b01:   alu_out = w_srcA - w_srcB;
      2'b10:   alu_out = w_srcA & w_srcB;
      default: alu_out = w_srcA | w_srcB;
    endcase
  end

  assign zero = (alu_out == 32'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_IF;
    else if (tick)
      r_state <= w_next;
  end

  always_comb begin
    w_next     = S_IF;
    w_wPc      = 1'b0;
    w_wMem     = 1'b0;
    w_wDr      = 1'b0;
    w_wIr      = 1'b0;
    w_wC       = 1'b0;
    w_wA       = 1'b0;
    w_wB       = 1'b0;
    w_wReg     = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    pcsource   = 2'b00;
    alu_ctrl   = 2'b00;
    alu_srcA   = 1'b0;
    alu_srcB   = 2'b00;
    insn_stage = 3'd0;
    case (r_state)
      S_IF: begin
        alu_srcB = 2'b01;
        w_wIr    = 1'b1;
        w_wPc    = 1'b1;
        w_next   = S_ID;
      end
      S_ID: begin
        insn_stage = 3'd1;
        alu_srcB   = 2'b11;
        w_wA       = 1'b1;
        w_wB       = 1'b1;
        w_wC       = 1'b1;
        case (insn_type)
          4'd1:       w_next = S_R_EX;
          4'd2:       w_next = S_I_EX;
          4'd3, 4'd4: w_next = S_MEM_ADDR;
          4'd5:       w_next = S_BEQ;
          4'd6:       w_next = S_J;
          default:    w_next = S_IF;
        endcase
      end
      S_MEM_ADDR: begin
        insn_stage = 3'd2;
        alu_srcA   = 1'b1;
        alu_srcB   = 2'b10;
        w_wC       = 1'b1;
        if (insn_type == 4'd3)
          w_next = S_MEM_RD;
        else if (insn_type == 4'd4)
          w_next = S_SW;
      end
      S_MEM_RD: begin
        insn_stage = 3'd3;
        iord       = 1'b1;
        w_wDr      = 1'b1;
        w_next     = S_LW_WB;
      end
      S_LW_WB: begin
        insn_stage = 3'd4;
        memtoreg   = 1'b1;
        w_wReg     = 1'b1;
      end
      S_SW: begin
        insn_stage = 3'd3;
        iord       = 1'b1;
        w_wMem     = 1'b1;
      end
      S_R_EX, S_I_EX: begin
        insn_stage = 3'd2;
        alu_srcA   = 1'b1;
        alu_srcB   = (r_state == S_I_EX) ? 2'b10 : 2'b00;
        alu_ctrl   = insn_code[1:0];
        w_wC       = 1'b1;
        w_next     = (r_state == S_I_EX) ? S_I_WB : S_R_WB;
      end
      S_R_WB: begin
        insn_stage = 3'd3;
        regdst     = 1'b1;
        w_wReg     = 1'b1;
      end
      S_I_WB: begin
        insn_stage = 3'd3;
        w_wReg     = 1'b1;
      end
      S_BEQ: begin
        insn_stage = 3'd2;
        alu_srcA   = 1'b1;
        alu_ctrl   = 2'b01;
        pcsource   = 2'b01;
      end
      S_J: begin
        insn_stage = 3'd2;
        pcsource   = 2'b10;
        w_wPc      = 1'b1;
      end
      default: w_next = S_IF;
    endcase
  end

  // The branch strobe depends on the ALU result, kept out of the FSM block
  // so the select-to-zero path does not loop back into it.
  assign w_beqPc = (r_state == S_BEQ) && zero;
  assign w_gate  = tick & rst;

  assign write_pc  = (w_wPc | w_beqPc) & w_gate;
  assign write_mem = w_wMem & w_gate;
  assign write_dr  = w_wDr & w_gate;
  assign write_ir  = w_wIr & w_gate;
  assign write_c   = w_wC & w_gate;
  assign write_a   = w_wA & w_gate;
  assign write_b   = w_wB & w_gate;
  assign write_reg = w_wReg & w_gate;
  assign state_out = r_state;

endmodule

// File: tb/tb_mcpu_ctrl_alu.sv
// Self-checking bench for mcpu_ctrl_alu: a per-instruction sequence model
// checked every cycle, plus directed literal expectations.
module tb_mcpu_ctrl_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] div, ir_data, a_data, b_data, pc;
  logic        tick, write_pc, iord, write_mem, write_dr, write_ir, write_c;
  logic        write_a, write_b, write_reg, memtoreg, regdst, alu_srcA, zero;
  logic [1:0]  pcsource, alu_ctrl, alu_srcB;
  logic [31:0] alu_out;
  logic [3:0]  state_out, insn_type, insn_code;
  logic [2:0]  insn_stage;

  int errors = 0;
  int checks = 0;

  mcpu_ctrl_alu dut (
    .clk(clk), .rst(rst), .div(div), .ir_data(ir_data), .a_data(a_data),
    .b_data(b_data), .pc(pc), .tick(tick), .write_pc(write_pc), .iord(iord),
    .write_mem(write_mem), .write_dr(write_dr), .write_ir(write_ir),
    .write_c(write_c), .write_a(write_a), .write_b(write_b),
    .write_reg(write_reg), .memtoreg(memtoreg), .regdst(regdst),
    .pcsource(pcsource), .alu_ctrl(alu_ctrl), .alu_srcA(alu_srcA),
    .alu_srcB(alu_srcB), .alu_out(alu_out), .zero(zero),
    .state_out(state_out), .insn_type(insn_type), .insn_code(insn_code),
    .insn_stage(insn_stage)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- specification-level model ----------------
  typedef struct packed {
    logic [7:0] wr;    // pc, mem, dr, ir, c, a, b, reg
    logic       iord;
    logic       m2r;
    logic       rdst;
    logic [1:0] pcs;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] ac;
  } ctl_t;

  function automatic int typeOf(input logic [31:0] ir);
    logic [5:0] op, fn;
    op = ir[31:26];
    fn = ir[5:0];
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25)) return 1;
    if (op == 6'h08 || op == 6'h0C || op == 6'h0D) return 2;
    if (op == 6'h23) return 3;
    if (op == 6'h2B) return 4;
    if (op == 6'h04) return 5;
    if (op == 6'h02) return 6;
    return 0;
  endfunction

  function automatic int codeOf(input logic [31:0] ir);
    int t;
    t = typeOf(ir);
    if (t == 1) return int'(ir[5:0]) == 'h20 ? 0 : int'(ir[5:0]) == 'h22 ? 1 : int'(ir[5:0]) == 'h24 ? 2 : 3;
    if (t == 2) return int'(ir[31:26]) == 'h08 ? 0 : int'(ir[31:26]) == 'h0C ? 2 : 3;
    return 0;
  endfunction

  // Tick count per instruction class: invalid, R, I, lw, sw, beq, j.
  function automatic int seqLen(input int cls);
    case (cls)
      1, 2, 4: return 4;
      3:       return 5;
      5, 6:    return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int stateAt(input int cls, input int pos);
    if (pos < 2) return pos;
    case (cls)
      1: return pos == 2 ? 6 : 7;
      2: return pos == 2 ? 10 : 11;
      3: return pos + 0;
      4: return pos == 2 ? 2 : 5;
      5: return 8;
      6: return 9;
      default: return 0;
    endcase
  endfunction

  function automatic int stageOf(input int st);
    case (st)
      0: return 0;
      1: return 1;
      4: return 4;
      3, 5, 7, 11: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] aluOp(input int code, input logic [31:0] x, input logic [31:0] y);
    case (code)
      0: return x + y;
      1: return x - y;
      2: return x & y;
      default: return x | y;
    endcase
  endfunction

  function automatic logic expAlu(input int st, output logic [31:0] v);
    logic [31:0] sx, ex;
    sx = {{16{ir_data[15]}}, ir_data[15:0]};
    ex = (ir_data[31:26] == 6'h0C || ir_data[31:26] == 6'h0D) ? {16'h0, ir_data[15:0]} : sx;
    v = 32'd0;
    case (st)
      0:  v = pc + 32'd4;
      1:  v = pc + (sx << 2);
      2:  v = a_data + sx;
      6:  v = aluOp(codeOf(ir_data), a_data, b_data);
      8:  v = a_data - b_data;
      10: v = aluOp(codeOf(ir_data), a_data, ex);
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic ctl_t expCtl(input int st);
    ctl_t c;
    c = '0;
    case (st)
      0:  begin c.sb = 2'b01; c.wr = 8'b1001_0000; end
      1:  begin c.sb = 2'b11; c.wr = 8'b0000_1110; end
      2:  begin c.sa = 1'b1; c.sb = 2'b10; c.wr = 8'b0000_1000; end
      3:  begin c.iord = 1'b1; c.wr = 8'b0010_0000; end
      4:  begin c.m2r = 1'b1; c.wr = 8'b0000_0001; end
      5:  begin c.iord = 1'b1; c.wr = 8'b0100_0000; end
      6:  begin c.sa = 1'b1; c.ac = 2'(codeOf(ir_data)); c.wr = 8'b0000_1000; end
      7:  begin c.rdst = 1'b1; c.wr = 8'b0000_0001; end
      8:  begin c.sa = 1'b1; c.ac = 2'b01; c.pcs = 2'b01; c.wr = {a_data == b_data, 7'b0}; end
      9:  begin c.pcs = 2'b10; c.wr = 8'b1000_0000; end
      10: begin c.sa = 1'b1; c.sb = 2'b10; c.ac = 2'(codeOf(ir_data)); c.wr = 8'b0000_1000; end
      11: begin c.wr = 8'b0000_0001; end
      default: ;
    endcase
    return c;
  endfunction

  int mPhase, mPeriod, mPos, mCls;

  // Model advances one instruction step on each expected tick and restarts
  // the divider period length whenever its phase returns to zero.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mPhase = 0; mPeriod = 1; mPos = 0; mCls = 0;
    end else begin
      if (mPhase == 0) begin
        if (mPos == 1) mCls = typeOf(ir_data);
        if (mPos + 1 >= seqLen(mCls)) mPos = 0; else mPos++;
        mPeriod = (div == 32'd0) ? 1 : int'(div);
      end
      mPhase++;
      if (mPhase >= mPeriod) mPhase = 0;
    end
  end

  // Cycle-by-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    logic [7:0]  actWr;
    logic [31:0] ev;
    ctl_t        e;
    int          st;
    logic        tk;
    actWr = {write_pc, write_mem, write_dr, write_ir, write_c, write_a, write_b, write_reg};
    if (!rst) begin
      checkEq("rst_state", 32'(state_out), 32'd0);
      checkEq("rst_strobes", 32'(actWr), 32'd0);
    end else begin
      st = stateAt(mCls, mPos);
      tk = (mPhase == 0);
      e  = expCtl(st);
      checkEq("tick", 32'(tick), 32'(tk));
      checkEq("state", 32'(state_out), 32'(st));
      checkEq("stage", 32'(insn_stage), 32'(stageOf(st)));
      checkEq("type", 32'(insn_type), 32'(typeOf(ir_data)));
      checkEq("code", 32'(insn_code), 32'(codeOf(ir_data)));
      checkEq("strobes", 32'(actWr), tk ? 32'(e.wr) : 32'd0);
      checkEq("selects", 32'({iord, memtoreg, regdst, pcsource, alu_srcA, alu_srcB, alu_ctrl}),
              32'({e.iord, e.m2r, e.rdst, e.pcs, e.sa, e.sb, e.ac}));
      if (expAlu(st, ev)) begin
        checkEq("alu_out", alu_out, ev);
        checkEq("zero", 32'(zero), 32'(ev == 32'd0));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic waitTick(output int st);
    int n;
    st = -1;
    n  = 0;
    while (st < 0 && n < 64) begin
      @(negedge clk);
      #1;
      if (tick) st = int'(state_out);
      n++;
    end
    if (st < 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL tick_timeout: got no tick, expected one within 64 cycles");
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b);
    ir_data = ir;
    a_data  = a;
    b_data  = b;
  endtask

  task automatic checkOutput(input string name, input int st, input int expSt);
    checkEq(name, 32'(st), 32'(expSt));
  endtask

  initial begin
    int st, tickCnt, firstSt, secondSt, seen;
    div = 32'd1;
    pc  = 32'h0000_0100;
    applyStimulus(32'h0022_1820, 32'd5, 32'd7);
    repeat (3) @(negedge clk);
    #1;
    checkEq("lit_rst_state", 32'(state_out), 32'd0);
    checkEq("lit_rst_stage", 32'(insn_stage), 32'd0);
    checkEq("lit_rst_wir", 32'(write_ir), 32'd0);
    rst = 1'b1;
    #1;
    checkEq("lit_rel_tick", 32'(tick), 32'd1);
    checkEq("lit_rel_wir", 32'(write_ir), 32'd1);

    // add r3,r1,r2
    waitTick(st); checkOutput("add_s1", st, 1);
    waitTick(st); checkOutput("add_s2", st, 6);
    checkEq("add_alu", alu_out, 32'd12);
    checkEq("add_wc", 32'(write_c), 32'd1);
    waitTick(st); checkOutput("add_s3", st, 7);
    checkEq("add_wreg", 32'({write_reg, regdst}), 32'b11);
    waitTick(st); checkOutput("add_s4", st, 0);

    // lw
    applyStimulus(32'h8C22_0004, 32'd100, 32'd0);
    waitTick(st); checkOutput("lw_s1", st, 1);
    waitTick(st); checkOutput("lw_s2", st, 2);
    checkEq("lw_alu", alu_out, 32'd104);
    waitTick(st); checkOutput("lw_s3", st, 3);
    checkEq("lw_rd", 32'({iord, write_dr}), 32'b11);
    waitTick(st); checkOutput("lw_s4", st, 4);
    checkEq("lw_wb", 32'({memtoreg, write_reg}), 32'b11);
    waitTick(st); checkOutput("lw_s5", st, 0);

    // beq taken then not taken
    applyStimulus(32'h1022_0003, 32'd9, 32'd9);
    waitTick(st);
    waitTick(st); checkOutput("beq_s", st, 8);
    checkEq("beq_zero", 32'(zero), 32'd1);
    checkEq("beq_wpc", 32'(write_pc), 32'd1);
    checkEq("beq_pcs", 32'(pcsource), 32'd1);
    waitTick(st); checkOutput("beq_end", st, 0);
    applyStimulus(32'h1022_0003, 32'd9, 32'd8);
    waitTick(st);
    waitTick(st); checkOutput("bne_s", st, 8);
    checkEq("bne_wpc", 32'(write_pc), 32'd0);
    waitTick(st);

    // ori / addi immediates
    applyStimulus(32'h3422_FFFF, 32'd0, 32'd0);
    waitTick(st);
    waitTick(st); checkOutput("ori_s", st, 10);
    checkEq("ori_alu", alu_out, 32'h0000_FFFF);
    waitTick(st); waitTick(st);
    applyStimulus(32'h2022_FFFF, 32'd1, 32'd0);
    waitTick(st);
    waitTick(st); checkOutput("addi_s", st, 10);
    checkEq("addi_alu", alu_out, 32'd0);
    waitTick(st); waitTick(st); checkOutput("addi_end", st, 0);

    // div=4 with an invalid instruction
    div = 32'd4;
    applyStimulus(32'hFC00_0000, 32'd0, 32'd0);
    #1;
    checkEq("inv_type", 32'(insn_type), 32'd0);
    tickCnt = 0; seen = 0; firstSt = -1; secondSt = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1;
      if (tick) begin
        tickCnt++;
        if (seen == 0) firstSt = int'(state_out);
        if (seen == 1) secondSt = int'(state_out);
        seen++;
      end
    end
    checkEq("div4_ticks", 32'(tickCnt), 32'd4);
    checkOutput("inv_s1", firstSt, 1);
    checkOutput("inv_s2", secondSt, 0);

    // abort a lw in MEM_RD with reset
    div = 32'd1;
    st = -1;
    for (int i = 0; i < 16 && st != 0; i++) waitTick(st);
    applyStimulus(32'h8C22_0004, 32'd100, 32'd0);
    waitTick(st); waitTick(st); waitTick(st);
    checkOutput("abort_at", st, 3);
    rst = 1'b0;
    #1;
    checkEq("abort_state", 32'(state_out), 32'd0);
    checkEq("abort_strobes",
            32'({write_pc, write_mem, write_dr, write_ir, write_c, write_a, write_b, write_reg}), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkEq("resume_state", 32'(state_out), 32'd0);
    waitTick(st); checkOutput("resume_s1", st, 1);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
